// File: rtl/jtframe_joy_pkg.sv
// Shared types and bit positions for the serial joystick reader.
package jtframe_joy_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SAMPLE = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } joy_state_t;

  // Chain order of the six player bits within one player's group
  localparam int unsigned JOY_UP    = 0;
  localparam int unsigned JOY_DOWN  = 1;
  localparam int unsigned JOY_LEFT  = 2;
  localparam int unsigned JOY_RIGHT = 3;
  localparam int unsigned JOY_FIRE1 = 4;
  localparam int unsigned JOY_FIRE2 = 5;

  localparam int unsigned JOY2_BASE = 8;

endpackage

// File: rtl/jtframe_joy_shreg_if.sv
// Chain pins plus decoded joystick buses of the serial joystick reader.
interface jtframe_joy_shreg_if #(
  parameter int unsigned NBITS = 16
);
  logic             joy_data;
  logic             joy_clk;
  logic             joy_load;
  logic [5:0]       joy1;
  logic [5:0]       joy2;
  logic [NBITS-1:0] raw;
  logic             frame;

  modport master (
    input  joy_data,
    output joy_clk, joy_load, joy1, joy2, raw, frame
  );

  modport slave (
    output joy_data,
    input  joy_clk, joy_load, joy1, joy2, raw, frame
  );
endinterface

// File: rtl/jtframe_joy_tick.sv
// Free-running divider: tick_c is high on the last clk of every CLKDIV period.
module jtframe_joy_tick #(
  parameter int unsigned CLKDIV = 24
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_c
);
  localparam int unsigned CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [CW-1:0] cnt;

  assign tick_c = (cnt == CW'(CLKDIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)      cnt <= '0;
    else if (tick_c) cnt <= '0;
    else             cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/jtframe_joy_shreg.sv
// Drives a 74HC165-style chain, shifts in NBITS per frame and publishes a
// frame only after two identical consecutive reads.
module jtframe_joy_shreg
  import jtframe_joy_pkg::*;
#(
  parameter int unsigned CLKDIV = 24,
  parameter int unsigned NBITS  = 16
) (
  input  logic clk,
  input  logic rst_n,
  jtframe_joy_shreg_if.master bus
);
  localparam int unsigned IW = $clog2(NBITS);

  joy_state_t       state;
  logic [IW-1:0]    bit_idx;
  logic [NBITS-1:0] sh;
  logic [NBITS-1:0] prev;
  logic [NBITS-1:0] raw_q;
  logic [1:0]       data_sync;
  logic             joy_clk_q;
  logic             joy_load_q;
  logic             frame_q;
  logic             tick_c;

  jtframe_joy_tick #(
    .CLKDIV (CLKDIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_c (tick_c)
  );

  // joy_data is asynchronous to clk
  always_ff @(posedge clk) begin
    if (!rst_n) data_sync <= 2'b11;
    else        data_sync <= {data_sync[0], bus.joy_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      bit_idx    <= '0;
      sh         <= '1;
      prev       <= '1;
      raw_q      <= '1;
      joy_clk_q  <= 1'b0;
      joy_load_q <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (tick_c) begin
        unique case (state)
          LOAD: begin
            state      <= SAMPLE;
            bit_idx    <= '0;
            joy_load_q <= 1'b1;
            joy_clk_q  <= 1'b0;
          end
          SAMPLE: begin
            sh[bit_idx] <= data_sync[1];
            state       <= SHIFT;
            joy_clk_q   <= 1'b1;
          end
          SHIFT: begin
            joy_clk_q <= 1'b0;
            if (bit_idx == IW'(NBITS - 1)) begin
              state <= DONE;
            end else begin
              bit_idx <= bit_idx + IW'(1);
              state   <= SAMPLE;
            end
          end
          DONE: begin
            // A read only counts once it matches the previous frame
            if (sh == prev) raw_q <= sh;
            prev       <= sh;
            frame_q    <= 1'b1;
            state      <= LOAD;
            joy_load_q <= 1'b0;
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

  assign bus.joy_clk  = joy_clk_q;
  assign bus.joy_load = joy_load_q;
  assign bus.raw      = raw_q;
  assign bus.frame    = frame_q;

  // Reorder chain bits into {fire2, fire1, up, down, left, right}
  assign bus.joy1 = {raw_q[JOY_FIRE2], raw_q[JOY_FIRE1], raw_q[JOY_UP],
                     raw_q[JOY_DOWN],  raw_q[JOY_LEFT],  raw_q[JOY_RIGHT]};
  assign bus.joy2 = {raw_q[JOY2_BASE + JOY_FIRE2], raw_q[JOY2_BASE + JOY_FIRE1],
                     raw_q[JOY2_BASE + JOY_UP],    raw_q[JOY2_BASE + JOY_DOWN],
                     raw_q[JOY2_BASE + JOY_LEFT],  raw_q[JOY2_BASE + JOY_RIGHT]};
endmodule

// File: tb/tb_jtframe_joy_shreg.sv
// Directed bench for jtframe_joy_shreg with a behavioural 74HC165 chain model.
module tb_jtframe_joy_shreg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pat = 16'hFFFF;
  logic [15:0] chain = 16'hFFFF;
  logic        jclk_d = 1'b0;
  int          checks = 0;
  int          errors = 0;

  jtframe_joy_shreg_if #(.NBITS(16)) bus ();

  jtframe_joy_shreg #(
    .CLKDIV (4),
    .NBITS  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Chain model: parallel load while load is low, shift on joy_clk rising
  always @(negedge clk) begin
    if (!bus.joy_load)               chain = pat;
    else if (bus.joy_clk && !jclk_d) chain = {1'b1, chain[15:1]};
    jclk_d       = bus.joy_clk;
    bus.joy_data = chain[0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.frame && n < 400);
    if (!bus.frame) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n_load = 0, n_high = 0, n_rise = 0, n_frames = 0;
    int first = -1, last = -1, f1 = -1, f2 = -1, n;
    logic prev_jc = 1'b0;
    logic [15:0] raw_f1 = '0, raw_f2 = '0;
    logic [5:0]  joy1_f1 = '0, joy1_f2 = '0;

    // Reset
    pat = 16'hFFFF;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_load",  32'(bus.joy_load), 32'd0);
    check("rst_clk",   32'(bus.joy_clk),  32'd0);
    check("rst_joy1",  32'(bus.joy1),     32'h3F);
    check("rst_joy2",  32'(bus.joy2),     32'h3F);
    check("rst_raw",   32'(bus.raw),      32'hFFFF);
    check("rst_frame", 32'(bus.frame),    32'd0);

    // Waveform and press of joy1 up from the first frame on
    pat = 16'hFFFE;
    rst_n = 1'b1;
    for (int i = 0; i <= 272; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i < 136) begin
        if (!bus.joy_load) n_load++;
        if (bus.joy_clk) n_high++;
        if (bus.joy_clk && !prev_jc) begin
          n_rise++;
          if (first < 0) first = i;
          last = i;
        end
      end
      prev_jc = bus.joy_clk;
      if (bus.frame) begin
        n_frames++;
        if (f1 < 0) begin
          f1 = i; raw_f1 = bus.raw; joy1_f1 = bus.joy1;
        end else if (f2 < 0) begin
          f2 = i; raw_f2 = bus.raw; joy1_f2 = bus.joy1;
        end
      end
    end
    check("wave_load_low",   32'(n_load),   32'd4);
    check("wave_clk_high",   32'(n_high),   32'd64);
    check("wave_clk_pulses", 32'(n_rise),   32'd16);
    check("wave_first_rise", 32'(first),    32'd8);
    check("wave_last_rise",  32'(last),     32'd128);
    check("wave_frame1_at",  32'(f1),       32'd136);
    check("wave_frame2_at",  32'(f2),       32'd272);
    check("wave_nframes",    32'(n_frames), 32'd2);
    check("press_f1_raw",    32'(raw_f1),   32'hFFFF);
    check("press_f1_joy1",   32'(joy1_f1),  32'h3F);
    check("press_f2_raw",    32'(raw_f2),   32'hFFFE);
    check("press_f2_joy1",   32'(joy1_f2),  32'h37);

    // Reset during bit 7 of the following frame
    n = 0; n_rise = 0; prev_jc = bus.joy_clk;
    while (n_rise < 8 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (bus.joy_clk && !prev_jc) n_rise++;
      prev_jc = bus.joy_clk;
    end
    check("mid_bit7_reached", 32'(n_rise), 32'd8);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_raw",  32'(bus.raw),      32'hFFFF);
    check("mid_load", 32'(bus.joy_load), 32'd0);
    check("mid_clk",  32'(bus.joy_clk),  32'd0);
    check("mid_joy1", 32'(bus.joy1),     32'h3F);
    rst_n = 1'b1;
    wait_frame("mid_f1");
    check("mid_f1_raw", 32'(bus.raw), 32'hFFFF);
    wait_frame("mid_f2");
    check("mid_f2_raw",  32'(bus.raw),  32'hFFFE);
    check("mid_f2_joy1", 32'(bus.joy1), 32'h37);

    // Release, then a one-frame glitch on joy2 fire1
    pat = 16'hFFFF;
    wait_frame("rel_f1");
    check("rel_f1_raw", 32'(bus.raw), 32'hFFFE);
    wait_frame("rel_f2");
    check("rel_f2_raw", 32'(bus.raw), 32'hFFFF);
    pat = 16'hEFFF;
    wait_frame("glitch_f1");
    check("glitch_f1_raw",  32'(bus.raw),  32'hFFFF);
    check("glitch_f1_joy2", 32'(bus.joy2), 32'h3F);
    pat = 16'hFFFF;
    wait_frame("glitch_f2");
    check("glitch_f2_raw",  32'(bus.raw),  32'hFFFF);
    check("glitch_f2_joy2", 32'(bus.joy2), 32'h3F);
    wait_frame("glitch_f3");
    check("glitch_f3_raw",  32'(bus.raw),  32'hFFFF);

    // Mapping of a mixed pattern on both players
    pat = 16'b1101_1110_1111_0101;
    wait_frame("map_f1");
    check("map_f1_raw",  32'(bus.raw),  32'hFFFF);
    wait_frame("map_f2");
    check("map_f2_raw",   32'(bus.raw),   32'hDEF5);
    check("map_f2_joy1",  32'(bus.joy1),  32'b111010);
    check("map_f2_joy2",  32'(bus.joy2),  32'b010111);
    check("map_f2_frame", 32'(bus.frame), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
